// File: rtl/pipe_hazard_if.sv
// ID-stage instruction fields and hazard-control results exchanged between the
// core pipeline (master) and the hazard/forwarding controller (slave).
interface pipe_hazard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic             id_rs_used;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_setflags;
  logic             id_br_reg;
  logic             id_br_cond;
  logic             id_halt;
  logic             id_br_taken;

  logic             stall_if;
  logic             bubble_ex;
  logic             flush_ifid;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             rf_byp_a;
  logic             rf_byp_b;
  logic             halt_o;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regwrite,
           id_memread, id_setflags, id_br_reg, id_br_cond, id_halt, id_br_taken,
    input  stall_if, bubble_ex, flush_ifid, fwd_a_sel, fwd_b_sel,
           rf_byp_a, rf_byp_b, halt_o, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regwrite,
           id_memread, id_setflags, id_br_reg, id_br_cond, id_halt, id_br_taken,
    output stall_if, bubble_ex, flush_ifid, fwd_a_sel, fwd_b_sel,
           rf_byp_a, rf_byp_b, halt_o, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the 5-stage core. Tracks the
// EX/MEM/WB occupants in a shadow scoreboard and derives stall/bubble/flush/forward.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_hazard_if.slave  hz_if
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             setflags;
    logic             halt;
  } sb_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  sb_t              r_s_ex, r_s_mem, r_s_wb;
  sb_t              w_s_ex_nxt;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [1:0]       w_sel_a, w_sel_b;
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic match(sb_t s, logic [REG_W-1:0] r, logic used);
    return used & s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction

  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic w_load_use, w_no_fwd, w_br_reg, w_flags, w_not_run;
  logic w_bubble, w_stall, w_issue, w_flush, w_enter;

  assign w_ex_a  = match(r_s_ex,  hz_if.id_rs, hz_if.id_rs_used);
  assign w_ex_b  = match(r_s_ex,  hz_if.id_rt, hz_if.id_rt_used);
  assign w_mem_a = match(r_s_mem, hz_if.id_rs, hz_if.id_rs_used);
  assign w_mem_b = match(r_s_mem, hz_if.id_rt, hz_if.id_rt_used);

  assign w_load_use = (w_ex_a | w_ex_b) & r_s_ex.memread;
  assign w_no_fwd   = (FWD_EN == 0) & (w_ex_a | w_ex_b | w_mem_a | w_mem_b);
  // BR consumes rs in ID, where no forwarding path exists.
  assign w_br_reg   = hz_if.id_br_reg & (match(r_s_ex, hz_if.id_rs, 1'b1) |
                                         match(r_s_mem, hz_if.id_rs, 1'b1));
  assign w_flags    = hz_if.id_br_cond & r_s_ex.valid & r_s_ex.setflags;
  assign w_not_run  = (r_state != RUN);

  assign w_bubble = hz_if.id_valid &
                    (w_load_use | w_no_fwd | w_br_reg | w_flags | w_not_run);
  assign w_stall  = w_bubble | w_not_run;
  assign w_issue  = hz_if.id_valid & ~w_stall;
  assign w_flush  = w_issue & hz_if.id_br_taken;
  assign w_enter  = w_issue & ~w_flush;

  // Nearer producer (EX/MEM) wins over the older one (MEM/WB).
  assign w_sel_a = (FWD_EN == 0) ? 2'b00 : w_ex_a ? 2'b01 : w_mem_a ? 2'b10 : 2'b00;
  assign w_sel_b = (FWD_EN == 0) ? 2'b00 : w_ex_b ? 2'b01 : w_mem_b ? 2'b10 : 2'b00;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_s_ex_nxt = '0;
    if (w_enter) begin
      w_s_ex_nxt.valid    = 1'b1;
      w_s_ex_nxt.rd       = hz_if.id_rd;
      w_s_ex_nxt.regwrite = hz_if.id_regwrite;
      w_s_ex_nxt.memread  = hz_if.id_memread;
      w_s_ex_nxt.setflags = hz_if.id_setflags;
      w_s_ex_nxt.halt     = hz_if.id_halt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_issue && hz_if.id_halt) w_state_nxt = DRAIN;
      DRAIN:   if (r_s_wb.valid && r_s_wb.halt) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_s_ex      <= '0;
      r_s_mem     <= '0;
      r_s_wb      <= '0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments make the scoreboard shift all stages
      // from their pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
      r_s_ex  <= w_s_ex_nxt;
      r_s_mem <= r_s_ex;
      r_s_wb  <= r_s_mem;
      r_fwd_a <= w_enter ? w_sel_a : 2'b00;
      r_fwd_b <= w_enter ? w_sel_b : 2'b00;
      if (w_stall && (r_state == RUN) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign hz_if.stall_if   = w_stall;
  assign hz_if.bubble_ex  = w_bubble;
  assign hz_if.flush_ifid = w_flush;
  assign hz_if.fwd_a_sel  = r_fwd_a;
  assign hz_if.fwd_b_sel  = r_fwd_b;
  assign hz_if.rf_byp_a   = match(r_s_wb, hz_if.id_rs, hz_if.id_rs_used);
  assign hz_if.rf_byp_b   = match(r_s_wb, hz_if.id_rt, hz_if.id_rt_used);
  assign hz_if.halt_o     = (r_s_wb.valid & r_s_wb.halt) | (r_state == HALTED);
  assign hz_if.stall_cnt  = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised hazard, forwarding and halt-drain controller for the 5-stage IF/ID/EX/MEM/WB core.
- Replaces the stub hazard detector and the hard-wired no-stall path.
- Keeps its own shadow scoreboard of the EX, MEM and WB occupants. From it, generates IF/ID stall, ID/EX bubble, registered EX forwarding selects, register-file bypass, branch flush and halt drain.
- Register-address width and forwarding mode are parametrised; a saturating stall counter supports performance runs.

Parameters:
REG_W, 4, register address width (register 0 reads as zero and never creates a hazard)
FWD_EN, 1, 1 = forward EX/MEM and MEM/WB results into EX; 0 = no forwarding, stall until the producer reaches WB
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_W  ID source 1
id_rs_used  in  1  ID reads rs
id_rt  in  REG_W  ID source 2
id_rt_used  in  1  ID reads rt
id_rd  in  REG_W  ID destination
id_regwrite  in  1  ID writes rd
id_memread  in  1  ID is a load
id_setflags  in  1  ID updates FLAGS in EX
id_br_reg  in  1  ID is BR (reads rs in ID)
id_br_cond  in  1  ID is B/BR (reads FLAGS in ID)
id_halt  in  1  ID is HLT
id_br_taken  in  1  branch in ID resolved taken
stall_if  out  1  hold PC and IF/ID
bubble_ex  out  1  load a NOP into ID/EX
flush_ifid  out  1  replace IF/ID with NOP
fwd_a_sel  out  2  EX operand A source: 00 = ID/EX, 01 = EX/MEM, 10 = MEM/WB
fwd_b_sel  out  2  same encoding, operand B
rf_byp_a  out  1  WB write matches id_rs; use WB data in ID
rf_byp_b  out  1  WB write matches id_rt
halt_o  out  1  halt reached WB / core halted
stall_cnt  out  CNT_W  saturating count of stall_if cycles

Behaviour:
Reset (async, rst_n low):
- All scoreboard entries invalid; FSM = RUN.
- All outputs 0; stall_cnt = 0.

Scoreboard:
- Three entries S_EX, S_MEM, S_WB. Each holds {valid, rd, regwrite, memread, setflags, halt}.
- Every edge: S_WB <= S_MEM, S_MEM <= S_EX.
- S_EX <= ID fields when issuing; S_EX <= invalid when bubble_ex or flush, or when id_valid = 0.
- Issue occurs when id_valid & ~stall_if.

Match definition:
- match(S, r) = S.valid & S.regwrite & (S.rd == r) & (r != 0), for a used source r.

Stall causes (combinational, OR-ed):
- Load-use: match(S_EX, src) & S_EX.memread.
- FWD_EN = 0: match(S_EX, src) | match(S_MEM, src).
- BR register: id_br_reg & (match(S_EX, rs) | match(S_MEM, rs)). Register data is consumed in ID; there is no forwarding into ID.
- Flags: id_br_cond & S_EX.valid & S_EX.setflags.
- FSM in DRAIN or HALTED.

Stall outputs:
- stall_if = bubble_ex = any stall cause, gated by id_valid. In DRAIN/HALTED stall_if = 1 regardless of id_valid.

Forwarding (FWD_EN = 1):
- Selects are computed at issue time and registered, valid in the same cycle the instruction occupies EX.
- Nearer producer wins: match(S_EX) gives 01, else match(S_MEM) gives 10, else 00.
- Registered selects clear to 00 on bubble/flush.
- FWD_EN = 0: selects are constant 00.

RF bypass:
- rf_byp_a/b = match(S_WB, id_rs/id_rt), combinational.

Flush:
- flush_ifid = id_br_taken & id_valid & ~stall_if.
- Single cycle. Stall has priority, so a stalled branch never flushes.

Halt FSM (RUN -> DRAIN -> HALTED):
- RUN -> DRAIN when HLT issues.
- DRAIN -> HALTED when S_WB.halt is set.
- HALTED holds until reset.
- halt_o = S_WB.valid & S_WB.halt, or FSM == HALTED.
- After HLT issues, nothing further issues: the ID instruction is held, and bubbles fill the pipe behind HLT.

Stall counter:
- Increments on each stall_if cycle in RUN only.
- Saturates at 2^CNT_W - 1; no wrap.

Simultaneous events:
- A load-use stall and a flags stall in the same cycle produce one stall cycle, counted once.
- Reset mid-DRAIN returns to RUN with the scoreboard empty.

Test Plan:
1. ADD R1,R2,R3 then ADD R4,R1,R5 back-to-back, FWD_EN = 1 -> no stall; fwd_a_sel = 01 in the second ADD's EX cycle.
2. LW R1 then ADD R4,R5,R1 -> stall_if = bubble_ex = 1 for exactly 1 cycle; then fwd_b_sel = 10; stall_cnt = 1.
3. FWD_EN = 0, ADD R1 then SUB R6,R1,R1 -> 2 stall cycles; fwd selects stay 00; rf_byp_a = rf_byp_b = 1 in the issuing cycle.
4. SUB (setflags) then B taken -> 1 stall cycle, then flush_ifid = 1 for 1 cycle. LW R5 then BR R5 -> 2 stall cycles.
5. ADD R0,R1,R2 then ADD R3,R0,R0 -> no stall; selects 00. With CNT_W = 4 and 20 forced stall cycles -> stall_cnt = 15.
6. HLT issued at cycle t -> halt_o = 1 at t+3 and stays 1; stall_if = 1 from t+1. rst_n pulsed low at t+2 -> all outputs 0 immediately, FSM = RUN.
